// File: rtl/led_pkg.sv
// Shared types and constants for the LED PWM fader.
package led_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_RISE = 2'b01,
    ST_ON   = 2'b10,
    ST_FALL = 2'b11
  } ch_state_e;

  localparam int NUM_LEDS_DEFAULT = 3;
  localparam int CLK_HZ = 50_000_000;

endpackage

// File: rtl/led_fade_channel.sv
// One fade channel: ramp FSM, brightness level and PWM output flop.
// Macro LED_FADER_GAMMA_EN selects a square-law compare value.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                step_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                ramp_o
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  ch_state_e           state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] cmp;
  logic                led_q, led_d;

  // A request change wins the state; the level step keeps the old direction.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      ST_OFF: begin
        if (req_i) state_d = ST_RISE;
      end
      ST_RISE: begin
        if (!req_i) state_d = ST_FALL;
        if (step_tick_i) begin
          if (level_q >= MAX - ONE) begin
            level_d = MAX;
            if (req_i) state_d = ST_ON;
          end else begin
            level_d = level_q + ONE;
          end
        end
      end
      ST_ON: begin
        if (!req_i) state_d = ST_FALL;
      end
      ST_FALL: begin
        if (req_i) state_d = ST_RISE;
        if (step_tick_i) begin
          if (level_q <= ONE) begin
            level_d = '0;
            if (!req_i) state_d = ST_OFF;
          end else begin
            level_d = level_q - ONE;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq  = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
  assign cmp = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign cmp = level_q;
`endif

  assign led_d  = (level_q == MAX) | (pwm_cnt_i < cmp);
  assign ramp_o = (state_q == ST_RISE) | (state_q == ST_FALL);
  assign led_o  = led_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/led_fader.sv
// PWM cross-fader between the LED sequencer and the board pins.
// Macro LED_FADER_GAMMA_EN enables square-law brightness in each channel.
module led_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEFAULT,
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 48828
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] led_req,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_DIV - 1);

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                busy_q, busy_d;
  logic                step_tick;
  logic [NUM_LEDS-1:0] ramp;

  assign step_tick = (presc_q == PS_LAST);
  assign presc_d   = step_tick ? '0 : presc_q + PS_W'(1);
  assign pwm_d     = pwm_q + PWM_BITS'(1);
  assign busy_d    = |ramp;
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .req_i      (led_req[i]),
      .step_tick_i(step_tick),
      .pwm_cnt_i  (pwm_q),
      .led_o      (led_out[i]),
      .ramp_o     (ramp[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed-vector bench for led_fader (PWM_BITS=4, RAMP_DIV=64).
module tb_led_fader;

`ifdef LED_FADER_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  typedef struct {
    int         e;
    logic [2:0] led;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] led_req = 3'b000;
  logic [2:0] led_out;
  logic       busy;

  int   nerr = 0;
  int   nchk = 0;
  int   cur_edge = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  led_fader #(
    .NUM_LEDS(3),
    .PWM_BITS(4),
    .RAMP_DIV(64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .led_req(led_req),
    .led_out(led_out),
    .busy   (busy)
  );

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] req);
    rst = 1'b1;
    led_req = req;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_edge = 0;
  endtask

  // Advance to 1 time unit after rising edge n counted from reset release.
  task automatic goto(input int n);
    while (cur_edge < n) begin
      @(posedge clk);
      cur_edge++;
    end
    #1;
  endtask

  task automatic run_vecs(input string tag);
    foreach (tv[k]) begin
      goto(tv[k].e);
      chk($sformatf("%s@%0d led", tag, tv[k].e), {1'b0, led_out},
          {1'b0, tv[k].led});
      chk($sformatf("%s@%0d busy", tag, tv[k].e), {3'b0, busy},
          {3'b0, tv[k].busy});
    end
    tv.delete();
  endtask

  initial begin
    int hi;

    // reset state while rst is held
    #2;
    chk("rst led", {1'b0, led_out}, 4'h0);
    chk("rst busy", {3'b0, busy}, 4'h0);

    // full rise of channel 0
    do_reset(3'b001);
    tv.push_back(vec_t'{1, 3'b000, 1'b0});
    tv.push_back(vec_t'{2, 3'b000, 1'b1});
    tv.push_back(vec_t'{65, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{66, 3'b000, 1'b1});
    tv.push_back(vec_t'{528, 3'b000, 1'b1});
    tv.push_back(vec_t'{529, 3'b001, 1'b1});
    tv.push_back(vec_t'{536, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{537, 3'b000, 1'b1});
    tv.push_back(vec_t'{958, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{959, 3'b000, 1'b1});
    tv.push_back(vec_t'{960, 3'b000, 1'b1});
    tv.push_back(vec_t'{961, 3'b001, 1'b0});
    tv.push_back(vec_t'{962, 3'b001, 1'b0});
    tv.push_back(vec_t'{1000, 3'b001, 1'b0});
    run_vecs("rise");

    // duty at level 8 over one PWM period
    do_reset(3'b001);
    goto(528);
    chk("duty pre-edge", {3'b0, led_out[0]}, 4'h0);
    goto(529);
    chk("duty lead edge", {3'b0, led_out[0]}, 4'h1);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      goto(cur_edge + 1);
      if (led_out[0]) hi++;
    end
    chk("duty count", 4'(hi), GAMMA ? 4'd4 : 4'd8);

    // asynchronous reset mid-ramp
    do_reset(3'b001);
    goto(300);
    chk("mid busy", {3'b0, busy}, 4'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("async led", {1'b0, led_out}, 4'h0);
    chk("async busy", {3'b0, busy}, 4'h0);
    do_reset(3'b001);
    tv.push_back(vec_t'{64, 3'b000, 1'b1});
    tv.push_back(vec_t'{65, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{66, 3'b000, 1'b1});
    run_vecs("restart");

    // reversal at level 5
    do_reset(3'b001);
    goto(320);
    led_req = 3'b000;
    tv.push_back(vec_t'{321, 3'b001, 1'b1});
    tv.push_back(vec_t'{322, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{385, 3'b001, 1'b1});
    tv.push_back(vec_t'{386, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{389, 3'b000, 1'b1});
    tv.push_back(vec_t'{577, GAMMA ? 3'b000 : 3'b001, 1'b1});
    tv.push_back(vec_t'{578, 3'b000, 1'b1});
    tv.push_back(vec_t'{640, 3'b000, 1'b1});
    tv.push_back(vec_t'{641, 3'b000, 1'b0});
    tv.push_back(vec_t'{700, 3'b000, 1'b0});
    run_vecs("rev");

    // cross-fade 100 -> 010 -> 001
    do_reset(3'b100);
    tv.push_back(vec_t'{961, 3'b100, 1'b0});
    tv.push_back(vec_t'{2000, 3'b100, 1'b0});
    run_vecs("xf1");
    led_req = 3'b010;
    tv.push_back(vec_t'{2001, 3'b100, 1'b0});
    tv.push_back(vec_t'{2002, 3'b100, 1'b1});
    tv.push_back(vec_t'{2049, GAMMA ? 3'b100 : 3'b110, 1'b1});
    tv.push_back(vec_t'{2050, 3'b100, 1'b1});
    tv.push_back(vec_t'{2944, 3'b000, 1'b1});
    tv.push_back(vec_t'{2945, 3'b010, 1'b0});
    tv.push_back(vec_t'{3000, 3'b010, 1'b0});
    tv.push_back(vec_t'{4000, 3'b010, 1'b0});
    run_vecs("xf2");
    led_req = 3'b001;
    tv.push_back(vec_t'{4001, 3'b010, 1'b0});
    tv.push_back(vec_t'{4002, 3'b010, 1'b1});
    tv.push_back(vec_t'{4033, GAMMA ? 3'b010 : 3'b011, 1'b1});
    tv.push_back(vec_t'{4929, 3'b001, 1'b0});
    tv.push_back(vec_t'{5500, 3'b001, 1'b0});
    run_vecs("xf3");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
